sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of storage slots; SHALL be a power of two, >= 4.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 wr_en_i  input  1  write request; one word per cycle.
REQ-006 rd_en_i  input  1  read request; one word per cycle.
REQ-007 write_data_i  input  WIDTH  word to write.
REQ-008 full_o  output  1  high when no further write will be accepted.
REQ-009 empty_o  output  1  high when no data is stored.
REQ-010 read_data_o  output  WIDTH  registered read data.

Function
REQ-011 Storage: circular buffer of DEPTH words, with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits wide; pointers SHALL wrap modulo DEPTH.
REQ-012 Usable capacity SHALL be DEPTH-1 words; one slot always stays unused.
REQ-013 empty_o SHALL be combinational: high iff wr_ptr == rd_ptr.
REQ-014 full_o SHALL be combinational: high iff (wr_ptr+1) mod DEPTH == rd_ptr.
REQ-015 Accepted write: wr_en_i=1 and full_o=0 at the clock edge.
  - mem[wr_ptr] <= write_data_i.
  - wr_ptr increments.
REQ-016 Write with full_o=1 SHALL be ignored: no memory change, no pointer change, no error flag. This holds even if a read occurs in the same cycle.
REQ-017 Accepted read: rd_en_i=1 and empty_o=0 at the clock edge.
  - read_data_o <= mem[rd_ptr].
  - rd_ptr increments.
  - Data is visible one cycle after the read request (1-cycle latency).
REQ-018 Read with empty_o=1 SHALL be ignored: read_data_o and rd_ptr hold. This holds even if a write occurs in the same cycle.
REQ-019 read_data_o SHALL hold its last value whenever no read is accepted.
REQ-020 Simultaneous accepted read and write: both SHALL execute in the same cycle. Occupancy is unchanged, and full_o/empty_o keep their values.
REQ-021 Data SHALL leave in strict write order (FIFO), including across pointer wrap-around.
REQ-022 full_o and empty_o SHALL never be high at the same time.

Reset
REQ-023 While rst=1 at a clock edge:
  - wr_ptr=0, rd_ptr=0, read_data_o=0.
  - Therefore empty_o=1 and full_o=0.
  - Memory contents need not be cleared.
REQ-024 Reset asserted mid-operation SHALL discard all stored data at that edge. Reset SHALL take priority over wr_en_i and rd_en_i.

Verification
REQ-025 Reset with DEPTH=8, WIDTH=8 -> empty_o=1, full_o=0, read_data_o=0.
REQ-026 Write values 0..6 as single-cycle pulses -> full_o=0 before each write; full_o=1 after the 7th write; empty_o=0.
REQ-027 When full, write 42 (and retry write 7) -> full_o stays 1; the later readout contains neither 42 nor 7.
REQ-028 Read 7 times -> read_data_o equals 0,1,…,6 one cycle after each rd_en_i pulse; empty_o=1 after the 7th read.
REQ-029 Read while empty -> empty_o stays 1; read_data_o stays 6.
REQ-030 Wrap and simultaneous access:
  - Stream 20 words while reading concurrently -> output order matches input order across the pointer wrap.
  - With 3 words stored, one cycle of simultaneous rd/wr -> full_o and empty_o unchanged.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and data bundle between a FIFO user (master) and sync_fifo (slave).
interface sync_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic             wr_en_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] write_data_i;
    logic             full_o;
    logic             empty_o;
    logic [WIDTH-1:0] read_data_o;

    modport master (
        output wr_en_i,
        output rd_en_i,
        output write_data_i,
        input  full_o,
        input  empty_o,
        input  read_data_o
    );

    modport slave (
        input  wr_en_i,
        input  rd_en_i,
        input  write_data_i,
        output full_o,
        output empty_o,
        output read_data_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO. DEPTH must be a power of two (>= 4);
// one slot is kept free so full and empty are distinguishable from the
// pointers alone, giving a usable capacity of DEPTH-1 words. Read data is
// registered and appears one cycle after an accepted read.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_read_data;

    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Status flags and accept decisions, derived purely from the pointers.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        w_full       = (w_wr_ptr_nxt == r_rd_ptr);
        w_empty      = (r_wr_ptr == r_rd_ptr);
        w_wr_acc     = bus.wr_en_i && !w_full;
        w_rd_acc     = bus.rd_en_i && !w_empty;
    end

    // Storage array; not reset, stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.write_data_i;
        end
    end

    // Write pointer: advances on each accepted write, wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= w_wr_ptr_nxt;
        end
    end

    // Read pointer and registered read data: update only on accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_read_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_read_data <= r_mem[r_rd_ptr];
        end
    end

    assign bus.full_o      = w_full;
    assign bus.empty_o     = w_empty;
    assign bus.read_data_o = r_read_data;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=8, WIDTH=8) using an occupancy
// model and a queue of expected read data.
module tb_sync_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CAP   = DEPTH - 1;

    logic clk;
    logic rst;

    sync_fifo_if #(.WIDTH(WIDTH)) bus ();

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_cmp;
    int unsigned      n_err;
    logic [WIDTH-1:0] sb_q[$];
    int unsigned      mdl_cnt;
    logic [WIDTH-1:0] exp_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_full"},  32'(bus.full_o),  32'(mdl_cnt == CAP));
        check({tag, "_empty"}, 32'(bus.empty_o), 32'(mdl_cnt == 0));
        check({tag, "_excl"},  32'(bus.full_o & bus.empty_o), 32'd0);
    endtask

    // One clock cycle of stimulus; model predicts acceptance from occupancy.
    task automatic cycle(input logic we, input logic re, input logic [WIDTH-1:0] wd, input string tag);
        logic wacc;
        logic racc;
        wacc = we && (mdl_cnt != CAP);
        racc = re && (mdl_cnt != 0);
        bus.wr_en_i      = we;
        bus.rd_en_i      = re;
        bus.write_data_i = wd;
        if (racc) exp_rd = sb_q.pop_front();
        if (wacc) sb_q.push_back(wd);
        @(posedge clk);
        #1;
        if (wacc && !racc) mdl_cnt++;
        if (racc && !wacc) mdl_cnt--;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        check({tag, "_rd"}, 32'(bus.read_data_o), 32'(exp_rd));
        check_flags(tag);
    endtask

    task automatic do_reset(input logic we, input logic re, input string tag);
        bus.wr_en_i      = we;
        bus.rd_en_i      = re;
        bus.write_data_i = 8'hA5;
        rst              = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        sb_q.delete();
        mdl_cnt = 0;
        exp_rd  = '0;
        check({tag, "_rd"}, 32'(bus.read_data_o), 32'd0);
        check_flags(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        mdl_cnt = 0;
        exp_rd  = '0;
        rst     = 1'b0;
        bus.wr_en_i      = 1'b0;
        bus.rd_en_i      = 1'b0;
        bus.write_data_i = '0;

        do_reset(1'b0, 1'b0, "reset");

        // Fill with 0..6; full must rise only after the seventh write.
        for (int i = 0; i < 7; i++) begin
            check("pre_wr_full", 32'(bus.full_o), 32'd0);
            cycle(1'b1, 1'b0, WIDTH'(i), "fill");
        end
        check("filled_full", 32'(bus.full_o), 32'd1);

        // Writes while full are dropped, even alongside nothing else.
        cycle(1'b1, 1'b0, 8'd42, "ovf42");
        cycle(1'b1, 1'b0, 8'd7,  "ovf7");

        // Drain: expect 0..6 in order, then empty.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, '0, "drain");
            check("drain_val", 32'(bus.read_data_o), 32'(i));
        end
        check("drained_empty", 32'(bus.empty_o), 32'd1);

        // Read while empty: data holds at 6; also with a write in same cycle.
        cycle(1'b0, 1'b1, '0, "udf");
        check("udf_hold", 32'(bus.read_data_o), 32'd6);
        cycle(1'b1, 1'b1, 8'd99, "udf_wr");
        check("udf_wr_hold", 32'(bus.read_data_o), 32'd6);
        cycle(1'b0, 1'b1, '0, "udf_wr_rd");

        // Full plus simultaneous read: write is dropped, read proceeds.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, WIDTH'(8'h10 + i), "refill");
        cycle(1'b1, 1'b1, 8'd77, "full_rw");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0, "full_rw_drain");

        // Stream 20 words with concurrent reads across pointer wrap.
        cycle(1'b1, 1'b0, 8'd100, "stream_prime");
        for (int i = 1; i < 20; i++) cycle(1'b1, 1'b1, WIDTH'(100 + i), "stream");
        cycle(1'b0, 1'b1, '0, "stream_last");
        check("stream_end", 32'(bus.read_data_o), 32'd119);

        // Three stored, one simultaneous rd/wr: flags unchanged.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, WIDTH'(200 + i), "three");
        cycle(1'b1, 1'b1, 8'd203, "three_rw");
        check("three_rw_full",  32'(bus.full_o),  32'd0);
        check("three_rw_empty", 32'(bus.empty_o), 32'd0);

        // Reset mid-operation with both enables high discards everything.
        do_reset(1'b1, 1'b1, "mid_reset");
        cycle(1'b0, 1'b1, '0, "post_reset_rd");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  WIDTH'($urandom_range(0, 255)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
